rf_wb_arbiter: RTL and testbench

- Writer-side front end for the integer register file write port (rd_wr_req / rd_addr / rd_data).
- Merges two writeback sources into the single RF write port:
  - the in-order pipeline writeback stage, which has priority;
  - the long-latency LSU/MDU completion path, buffered in a small FIFO.
- Drives the write port from registers so the RF's negative-edge write sees stable values for the full half-cycle.

---
 rtl/pcore_interface_defs.sv | 18 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/rf_wb_arbiter.sv | 109 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcore_interface_defs.sv
// Shared core interface definitions: register-file geometry and the writeback
// request record used by the RF write-port arbiter and its FIFO.
package pcore_interface_defs;

  localparam int RF_AWIDTH = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [RF_AWIDTH-1:0] rd_addr;
    logic [XLEN-1:0]      rd_data;
  } type_wb_req_s;

  // Writes to x0 are architecturally discarded.
  function automatic logic is_x0(input logic [RF_AWIDTH-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with occupancy count; push is ignored when full
// and pop is ignored when empty. Storage is not reset, only pointers and count.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// RF write-port front end: merges pipeline writeback (priority) with buffered
// LSU/MDU completions, with a starvation bound on the buffered source.
module rf_wb_arbiter
  import pcore_interface_defs::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_wb_valid_i,
  input  logic [RF_AWIDTH-1:0] pipe_wb_rd_addr_i,
  input  logic [XLEN-1:0]      pipe_wb_rd_data_i,
  output logic                 pipe_wb_ready_o,
  input  logic                 lsu_wb_valid_i,
  input  logic [RF_AWIDTH-1:0] lsu_wb_rd_addr_i,
  input  logic [XLEN-1:0]      lsu_wb_rd_data_i,
  output logic                 lsu_wb_ready_o,
  output logic                 wb2rf_rd_wr_req_o,
  output logic [RF_AWIDTH-1:0] wb2rf_rd_addr_o,
  output logic [XLEN-1:0]      wb2rf_rd_data_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  type_wb_req_s  lsu_req, fifo_head, grant_req;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          lsu_push, fifo_pop, force_fifo, pipe_win, grant_vld;

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          wr_req_q, wr_req_d;
  type_wb_req_s  out_q, out_d;

  assign lsu_req.rd_addr = lsu_wb_rd_addr_i;
  assign lsu_req.rd_data = lsu_wb_rd_data_i;
  assign lsu_push        = lsu_wb_valid_i & lsu_wb_ready_o;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(type_wb_req_s))
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (lsu_push),
    .push_data_i (lsu_req),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Ready depends only on registered state, so a full FIFO stays not-ready
  // even in a cycle where its head is dequeued.
  assign force_fifo      = (fifo_count != '0) & (starve_cnt_q == STARVE_MAX);
  assign pipe_wb_ready_o = ~rst & ~force_fifo;
  assign lsu_wb_ready_o  = ~rst & ~fifo_full;

  assign pipe_win = pipe_wb_valid_i & ~force_fifo;
  assign fifo_pop = ~pipe_win & ~fifo_empty;

  always_comb begin
    grant_vld = 1'b0;
    grant_req = '0;
    if (pipe_win) begin
      grant_vld         = 1'b1;
      grant_req.rd_addr = pipe_wb_rd_addr_i;
      grant_req.rd_data = pipe_wb_rd_data_i;
    end else if (fifo_pop) begin
      grant_vld = 1'b1;
      grant_req = fifo_head;
    end
  end

  // x0 grants still consume the request but never raise the write strobe.
  always_comb begin
    wr_req_d = grant_vld & ~is_x0(grant_req.rd_addr);
    out_d    = grant_vld ? grant_req : out_q;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (pipe_win && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      wr_req_q     <= 1'b0;
      out_q        <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_req_q     <= wr_req_d;
      out_q        <= out_d;
    end
  end

  assign wb2rf_rd_wr_req_o = wr_req_q;
  assign wb2rf_rd_addr_o   = out_q.rd_addr;
  assign wb2rf_rd_data_o   = out_q.rd_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized
// run compared against a queue-based reference model of the arbitration rules.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wb_valid_i = 1'b0;
  logic [4:0]  pipe_wb_rd_addr_i = '0;
  logic [31:0] pipe_wb_rd_data_i = '0;
  logic        pipe_wb_ready_o;
  logic        lsu_wb_valid_i = 1'b0;
  logic [4:0]  lsu_wb_rd_addr_i = '0;
  logic [31:0] lsu_wb_rd_data_i = '0;
  logic        lsu_wb_ready_o;
  logic        wb2rf_rd_wr_req_o;
  logic [4:0]  wb2rf_rd_addr_o;
  logic [31:0] wb2rf_rd_data_o;

  rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk               (clk),
    .rst               (rst),
    .pipe_wb_valid_i   (pipe_wb_valid_i),
    .pipe_wb_rd_addr_i (pipe_wb_rd_addr_i),
    .pipe_wb_rd_data_i (pipe_wb_rd_data_i),
    .pipe_wb_ready_o   (pipe_wb_ready_o),
    .lsu_wb_valid_i    (lsu_wb_valid_i),
    .lsu_wb_rd_addr_i  (lsu_wb_rd_addr_i),
    .lsu_wb_rd_data_i  (lsu_wb_rd_data_i),
    .lsu_wb_ready_o    (lsu_wb_ready_o),
    .wb2rf_rd_wr_req_o (wb2rf_rd_wr_req_o),
    .wb2rf_rd_addr_o   (wb2rf_rd_addr_o),
    .wb2rf_rd_data_o   (wb2rf_rd_data_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  int          starve;
  logic        e_pr, e_lr, e_req;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic        pipe_win, fifo_win, lsu_acc;
  logic        act_pr, act_lr;

  task automatic model_reset();
    mq.delete();
    starve = 0;
    e_req  = 1'b0;
    e_addr = '0;
    e_data = '0;
  endtask

  task automatic idle();
    pipe_wb_valid_i   = 1'b0;
    pipe_wb_rd_addr_i = '0;
    pipe_wb_rd_data_i = '0;
    lsu_wb_valid_i    = 1'b0;
    lsu_wb_rd_addr_i  = '0;
    lsu_wb_rd_data_i  = '0;
  endtask

  // One clock: sample readys before the edge, advance the model across it,
  // and return 1 time unit after the edge with outputs settled.
  task automatic tick();
    ent_t h;
    #1;
    act_pr   = pipe_wb_ready_o;
    act_lr   = lsu_wb_ready_o;
    e_pr     = !(mq.size() != 0 && starve == LIMIT);
    e_lr     = (mq.size() != DEPTH);
    pipe_win = pipe_wb_valid_i && e_pr;
    fifo_win = !pipe_win && (mq.size() != 0);
    lsu_acc  = lsu_wb_valid_i && e_lr;
    @(posedge clk);
    if (mq.size() == 0 || fifo_win) starve = 0;
    else if (pipe_win && starve < LIMIT) starve++;
    if (pipe_win) begin
      e_req  = (pipe_wb_rd_addr_i != 5'd0);
      e_addr = pipe_wb_rd_addr_i;
      e_data = pipe_wb_rd_data_i;
    end else if (fifo_win) begin
      h      = mq.pop_front();
      e_req  = (h.addr != 5'd0);
      e_addr = h.addr;
      e_data = h.data;
    end else begin
      e_req = 1'b0;
    end
    if (lsu_acc) mq.push_back('{lsu_wb_rd_addr_i, lsu_wb_rd_data_i});
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (8) tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (wb2rf_rd_wr_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", wb2rf_rd_wr_req_o); end
    total++; if (wb2rf_rd_addr_o !== 5'd0) begin bad++; $display("FAIL reset_addr: got %0h want 0", wb2rf_rd_addr_o); end
    total++; if (wb2rf_rd_data_o !== 32'd0) begin bad++; $display("FAIL reset_data: got %0h want 0", wb2rf_rd_data_o); end
    total++; if (pipe_wb_ready_o !== 1'b0) begin bad++; $display("FAIL reset_pipe_ready: got %b want 0", pipe_wb_ready_o); end
    total++; if (lsu_wb_ready_o !== 1'b0) begin bad++; $display("FAIL reset_lsu_ready: got %b want 0", lsu_wb_ready_o); end
    rst = 1'b0;
    model_reset();
    tick();
    total++; if (act_lr !== 1'b1 || act_pr !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b%b want 11", act_pr, act_lr); end
  endtask

  task automatic test_pipe_only();
    idle();
    pipe_wb_valid_i   = 1'b1;
    pipe_wb_rd_addr_i = 5'd5;
    pipe_wb_rd_data_i = 32'hDEADBEEF;
    tick();
    idle();
    total++; if (act_pr !== 1'b1) begin bad++; $display("FAIL pipe_ready: got %b want 1", act_pr); end
    total++; if (wb2rf_rd_wr_req_o !== 1'b1 || wb2rf_rd_addr_o !== 5'd5 || wb2rf_rd_data_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL pipe_write: got req=%b addr=%0d data=%h want req=1 addr=5 data=deadbeef",
                      wb2rf_rd_wr_req_o, wb2rf_rd_addr_o, wb2rf_rd_data_o);
    end
    tick();
    total++; if (wb2rf_rd_wr_req_o !== 1'b0 || wb2rf_rd_addr_o !== 5'd5) begin
      bad++; $display("FAIL pipe_one_cycle: got req=%b addr=%0d want req=0 addr=5", wb2rf_rd_wr_req_o, wb2rf_rd_addr_o);
    end
  endtask

  task automatic test_lsu_only();
    idle();
    lsu_wb_valid_i   = 1'b1;
    lsu_wb_rd_addr_i = 5'd7;
    lsu_wb_rd_data_i = 32'h12;
    tick();
    idle();
    total++; if (act_lr !== 1'b1 || wb2rf_rd_wr_req_o !== 1'b0) begin
      bad++; $display("FAIL lsu_accept: got ready=%b req=%b want ready=1 req=0", act_lr, wb2rf_rd_wr_req_o);
    end
    tick();
    total++; if (wb2rf_rd_wr_req_o !== 1'b1 || wb2rf_rd_addr_o !== 5'd7 || wb2rf_rd_data_o !== 32'h12) begin
      bad++; $display("FAIL lsu_write: got req=%b addr=%0d data=%h want req=1 addr=7 data=12",
                      wb2rf_rd_wr_req_o, wb2rf_rd_addr_o, wb2rf_rd_data_o);
    end
    tick();
    total++; if (wb2rf_rd_wr_req_o !== 1'b0) begin bad++; $display("FAIL lsu_one_cycle: got req=%b want 0", wb2rf_rd_wr_req_o); end
  endtask

  task automatic test_starvation();
    logic       exp_rdy [6];
    logic [4:0] exp_a   [6];
    int k = 0;
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_a   = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd3, 5'd14};
    for (int i = 0; i < 6; i++) begin
      pipe_wb_valid_i   = 1'b1;
      pipe_wb_rd_addr_i = 5'(10 + k);
      pipe_wb_rd_data_i = 32'h100 + 32'(k);
      lsu_wb_valid_i    = (i == 0);
      lsu_wb_rd_addr_i  = 5'd3;
      lsu_wb_rd_data_i  = 32'h33;
      tick();
      total++; if (act_pr !== exp_rdy[i]) begin bad++; $display("FAIL starve_ready[%0d]: got %b want %b", i, act_pr, exp_rdy[i]); end
      total++; if (wb2rf_rd_wr_req_o !== 1'b1 || wb2rf_rd_addr_o !== exp_a[i]) begin
        bad++; $display("FAIL starve_write[%0d]: got req=%b addr=%0d want req=1 addr=%0d", i, wb2rf_rd_wr_req_o, wb2rf_rd_addr_o, exp_a[i]);
      end
      if (act_pr) k++;
    end
    drain();
  endtask

  task automatic test_full_fifo();
    logic [4:0] got[$];
    int idx = 0;
    int accepts_before_drop = -1;
    for (int c = 0; c < 48; c++) begin
      pipe_wb_valid_i   = (c < 40);
      pipe_wb_rd_addr_i = 5'd1;
      pipe_wb_rd_data_i = $urandom;
      lsu_wb_valid_i    = (idx < 5);
      lsu_wb_rd_addr_i  = 5'(20 + idx);
      lsu_wb_rd_data_i  = 32'hA0 + 32'(idx);
      tick();
      if (lsu_wb_valid_i && !act_lr && accepts_before_drop < 0) accepts_before_drop = idx;
      if (lsu_wb_valid_i && act_lr) idx++;
      total++; if (wb2rf_rd_wr_req_o !== e_req || wb2rf_rd_addr_o !== e_addr || wb2rf_rd_data_o !== e_data) begin
        bad++; $display("FAIL full_model[%0d]: got %b/%0d/%h want %b/%0d/%h", c, wb2rf_rd_wr_req_o, wb2rf_rd_addr_o,
                        wb2rf_rd_data_o, e_req, e_addr, e_data);
      end
      if (wb2rf_rd_wr_req_o && wb2rf_rd_addr_o >= 5'd20) got.push_back(wb2rf_rd_addr_o);
    end
    total++; if (accepts_before_drop != 4) begin bad++; $display("FAIL full_drop: got %0d accepts want 4", accepts_before_drop); end
    total++; if (got.size() != 5) begin bad++; $display("FAIL full_drain_count: got %0d want 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      total++; if (got[i] !== 5'(20 + i)) begin bad++; $display("FAIL full_order[%0d]: got %0d want %0d", i, got[i], 20 + i); end
    end
    drain();
  endtask

  task automatic test_x0();
    idle();
    pipe_wb_valid_i   = 1'b1;
    pipe_wb_rd_addr_i = 5'd0;
    pipe_wb_rd_data_i = 32'hFFFFFFFF;
    lsu_wb_valid_i    = 1'b1;
    lsu_wb_rd_addr_i  = 5'd0;
    lsu_wb_rd_data_i  = $urandom;
    tick();
    idle();
    total++; if (act_pr !== 1'b1 || act_lr !== 1'b1) begin bad++; $display("FAIL x0_handshake: got %b%b want 11", act_pr, act_lr); end
    for (int i = 0; i < 4; i++) begin
      total++; if (wb2rf_rd_wr_req_o !== 1'b0) begin bad++; $display("FAIL x0_no_write[%0d]: got req=%b want 0", i, wb2rf_rd_wr_req_o); end
      tick();
    end
    // An entry left behind would force the pipe off within LIMIT+1 cycles.
    for (int i = 0; i < LIMIT + 2; i++) begin
      pipe_wb_valid_i   = 1'b1;
      pipe_wb_rd_addr_i = 5'd9;
      pipe_wb_rd_data_i = 32'(i);
      tick();
      total++; if (act_pr !== 1'b1) begin bad++; $display("FAIL x0_fifo_empty[%0d]: got pipe_ready=%b want 1", i, act_pr); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      pipe_wb_valid_i   = 1'b1;
      pipe_wb_rd_addr_i = 5'd2;
      pipe_wb_rd_data_i = 32'h55;
      lsu_wb_valid_i    = 1'b1;
      lsu_wb_rd_addr_i  = 5'(6 + i);
      lsu_wb_rd_data_i  = 32'h66;
      tick();
    end
    lsu_wb_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (wb2rf_rd_wr_req_o !== 1'b0 || wb2rf_rd_addr_o !== 5'd0 || wb2rf_rd_data_o !== 32'd0) begin
      bad++; $display("FAIL midreset_out: got %b/%0d/%h want 0/0/0", wb2rf_rd_wr_req_o, wb2rf_rd_addr_o, wb2rf_rd_data_o);
    end
    total++; if (pipe_wb_ready_o !== 1'b0 || lsu_wb_ready_o !== 1'b0) begin
      bad++; $display("FAIL midreset_ready: got %b%b want 00", pipe_wb_ready_o, lsu_wb_ready_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle();
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (wb2rf_rd_wr_req_o !== 1'b0) begin bad++; $display("FAIL midreset_no_write[%0d]: got req=%b want 0", i, wb2rf_rd_wr_req_o); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      pipe_wb_valid_i   = ($urandom_range(0, 99) < 60);
      pipe_wb_rd_addr_i = 5'($urandom_range(0, 31));
      pipe_wb_rd_data_i = $urandom;
      lsu_wb_valid_i    = ($urandom_range(0, 99) < 45);
      lsu_wb_rd_addr_i  = 5'($urandom_range(0, 31));
      lsu_wb_rd_data_i  = $urandom;
      tick();
      total++; if (act_pr !== e_pr || act_lr !== e_lr) begin
        bad++; $display("FAIL rand_ready[%0d]: got %b%b want %b%b", c, act_pr, act_lr, e_pr, e_lr);
      end
      total++; if (wb2rf_rd_wr_req_o !== e_req || wb2rf_rd_addr_o !== e_addr || wb2rf_rd_data_o !== e_data) begin
        bad++; $display("FAIL rand_out[%0d]: got %b/%0d/%h want %b/%0d/%h", c, wb2rf_rd_wr_req_o, wb2rf_rd_addr_o,
                        wb2rf_rd_data_o, e_req, e_addr, e_data);
      end
    end
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pipe_only();
    test_lsu_only();
    test_starvation();
    test_full_fifo();
    test_x0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
